// File: rtl/clause_variables_accumulator.sv
// Accumulates the union of integer/boolean variables referenced by a group of clause beats.
// Optional registered popcounts of the masks are built when CLAUSE_VARIABLES_ACCUMULATOR_COUNT_EN is defined.
module clause_variables_accumulator #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int CLAUSE_COUNT_WIDTH                          = 4
) (
  input  logic                                                    in_clk,
  input  logic                                                    in_reset_n,
  input  logic                                                    in_clear,
  input  logic                                                    in_valid,
  output logic                                                    out_ready,
  input  logic                                                    in_last,
  input  logic [((2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)+1)*MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] in_integer_coefficients,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)*2-1:0] in_boolean_coefficients,
  output logic                                                    out_valid,
  input  logic                                                    in_ready,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX)-1:0] out_integer_variables,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX)-1:0] out_boolean_variables,
  output logic                                                    out_empty,
  output logic [CLAUSE_COUNT_WIDTH-1:0]                           out_clause_count,
  output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX:0]    out_integer_count,
  output logic [MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX:0]    out_boolean_count
);

  localparam int IW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
  localparam int BW  = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX;
  localparam int CW  = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
  localparam int CCW = CLAUSE_COUNT_WIDTH;
  localparam int NI  = 2**IW;
  localparam int NB  = 2**BW;
  localparam int ICW = IW + 1;
  localparam int BCW = BW + 1;

  // state    | meaning
  // ST_IDLE  | waiting for the first beat of a group
  // ST_ACCUM | group open, OR-ing further beats in
  // ST_HOLD  | result presented, waiting for in_ready
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready_en;
  logic [NI-1:0]    r_int_mask;
  logic [NB-1:0]    r_bool_mask;
  logic [CCW-1:0]   r_count;
  logic [NI-1:0]    w_int_nxt;
  logic [NB-1:0]    w_bool_nxt;
  logic [CCW-1:0]   w_count_nxt;
  logic [NI-1:0]    w_beat_int;
  logic [NB-1:0]    w_beat_bool;
  logic             w_accept;
  logic             w_unused_bits;

  // Constant-term slot and boolean value bits never reach a mask.
  assign w_unused_bits = ^{in_integer_coefficients, in_boolean_coefficients};

  always_comb begin
    w_beat_int = '0;
    for (int i = 0; i < NI; i++) begin
      w_beat_int[i] = |in_integer_coefficients[CW*i +: CW];
    end
  end

  always_comb begin
    w_beat_bool = '0;
    for (int j = 0; j < NB; j++) begin
      w_beat_bool[j] = in_boolean_coefficients[2*j+1];
    end
  end

  assign out_ready = r_ready_en && (r_state != ST_HOLD);
  assign out_valid = (r_state == ST_HOLD);
  assign w_accept  = in_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (in_clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
        end
        ST_HOLD: begin
          if (in_ready) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_int_nxt   = r_int_mask;
    w_bool_nxt  = r_bool_mask;
    w_count_nxt = r_count;
    if (in_clear) begin
      w_int_nxt   = '0;
      w_bool_nxt  = '0;
      w_count_nxt = '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        w_int_nxt   = w_beat_int;
        w_bool_nxt  = w_beat_bool;
        w_count_nxt = CCW'(1);
      end else begin
        w_int_nxt   = r_int_mask | w_beat_int;
        w_bool_nxt  = r_bool_mask | w_beat_bool;
        w_count_nxt = (&r_count) ? r_count : r_count + CCW'(1);
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state     <= ST_IDLE;
      r_ready_en  <= 1'b0;
      r_int_mask  <= '0;
      r_bool_mask <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready_en  <= 1'b1;
      r_int_mask  <= w_int_nxt;
      r_bool_mask <= w_bool_nxt;
      r_count     <= w_count_nxt;
    end
  end

  assign out_integer_variables = r_int_mask;
  assign out_boolean_variables = r_bool_mask;
  assign out_clause_count      = r_count;
  assign out_empty             = ~(|r_int_mask) && ~(|r_bool_mask);

`ifdef CLAUSE_VARIABLES_ACCUMULATOR_COUNT_EN
  logic [ICW-1:0] w_int_pop_nxt;
  logic [BCW-1:0] w_bool_pop_nxt;
  logic [ICW-1:0] r_int_pop;
  logic [BCW-1:0] r_bool_pop;

  // Popcounts are taken from the next-state masks so they land in the same edge.
  always_comb begin
    w_int_pop_nxt = '0;
    for (int i = 0; i < NI; i++) begin
      w_int_pop_nxt = w_int_pop_nxt + ICW'(w_int_nxt[i]);
    end
  end

  always_comb begin
    w_bool_pop_nxt = '0;
    for (int j = 0; j < NB; j++) begin
      w_bool_pop_nxt = w_bool_pop_nxt + BCW'(w_bool_nxt[j]);
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_int_pop  <= '0;
      r_bool_pop <= '0;
    end else begin
      r_int_pop  <= w_int_pop_nxt;
      r_bool_pop <= w_bool_pop_nxt;
    end
  end

  assign out_integer_count = r_int_pop;
  assign out_boolean_count = r_bool_pop;
`else
  assign out_integer_count = '0;
  assign out_boolean_count = '0;
`endif

endmodule
